// File: rtl/branch_resolve_stage_if.sv
// Handshake bundle between the comparison unit, the branch resolver and fetch.
// The master drives branch inputs, out_ready and redirect_ack; the slave is the stage.
interface branch_resolve_stage_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic             in_predicate;
    logic             in_pred_taken;
    logic [WIDTH-1:0] in_pc;
    logic [WIDTH-1:0] in_offset;
    logic             out_valid;
    logic             out_ready;
    logic             out_taken;
    logic [WIDTH-1:0] out_target;
    logic [WIDTH-1:0] out_redirect_pc;
    logic             out_mispredict;
    logic             flush_req;
    logic             redirect_ack;

    modport master (
        output in_valid, in_predicate, in_pred_taken, in_pc, in_offset,
        output out_ready, redirect_ack,
        input  in_ready, out_valid, out_taken, out_target,
        input  out_redirect_pc, out_mispredict, flush_req
    );

    modport slave (
        input  in_valid, in_predicate, in_pred_taken, in_pc, in_offset,
        input  out_ready, redirect_ack,
        output in_ready, out_valid, out_taken, out_target,
        output out_redirect_pc, out_mispredict, flush_req
    );
endinterface

// File: rtl/branch_resolve_stage.sv
// Branch resolver: computes direction/target/redirect, buffers results in a FIFO
// and squashes wrong-path branches. Optional counters: BRANCH_RESOLVE_STATS_EN.
module branch_resolve_stage #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 2,
    parameter int INSN_BYTES = 4
) (
    input  logic clk,
    input  logic rst,
    branch_resolve_stage_if.slave bus
`ifdef BRANCH_RESOLVE_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts,
    output logic [31:0] stat_squashed
`endif
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    typedef enum logic {RUN, SQUASH} state_t;

    typedef struct packed {
        logic             taken;
        logic             mispredict;
        logic [WIDTH-1:0] target;
        logic [WIDTH-1:0] redirect;
    } entry_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    entry_t          mem_q [DEPTH];
    entry_t          head;
    entry_t          res;

    logic accept, push, pop, discard;

    assign bus.in_ready = !rst
                        && ((state_q == SQUASH) || (count_q < CW'(DEPTH)));
    assign accept  = bus.in_valid && bus.in_ready;
    assign push    = accept && (state_q == RUN);
    assign discard = accept && (state_q == SQUASH);
    assign pop     = bus.out_valid && bus.out_ready;

    always_comb begin
        res            = '0;
        res.taken      = bus.in_predicate;
        res.mispredict = bus.in_predicate ^ bus.in_pred_taken;
        res.target     = bus.in_pc + bus.in_offset;
        res.redirect   = bus.in_predicate ? res.target
                                          : bus.in_pc + WIDTH'(INSN_BYTES);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:    if (push && res.mispredict) state_d = SQUASH;
            SQUASH: if (bus.redirect_ack) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (push && !pop) count_d = count_q + CW'(1);
        if (!push && pop) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RUN;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            if (push) mem_q[wr_ptr_q] <= res;
        end
    end

    assign head                = mem_q[rd_ptr_q];
    assign bus.out_valid       = (count_q != '0);
    assign bus.out_taken       = head.taken;
    assign bus.out_target      = head.target;
    assign bus.out_redirect_pc = head.redirect;
    assign bus.out_mispredict  = head.mispredict;
    assign bus.flush_req       = (state_q == SQUASH);

`ifdef BRANCH_RESOLVE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
            stat_squashed    <= '0;
        end else begin
            if (push) stat_branches <= stat_branches + 32'd1;
            if (push && res.mispredict)
                stat_mispredicts <= stat_mispredicts + 32'd1;
            if (discard) stat_squashed <= stat_squashed + 32'd1;
        end
    end
`else
    logic unused_discard;
    assign unused_discard = discard;
`endif
endmodule

// File: tb/tb_branch_resolve_stage.sv
// Directed bench for branch_resolve_stage: resolve, squash, backpressure,
// wrap-around and asynchronous reset.
module tb_branch_resolve_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    branch_resolve_stage_if #(.WIDTH(32)) bus ();

`ifdef BRANCH_RESOLVE_STATS_EN
    logic [31:0] stat_branches, stat_mispredicts, stat_squashed;
`endif

    branch_resolve_stage #(
        .WIDTH(32), .DEPTH(2), .INSN_BYTES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef BRANCH_RESOLVE_STATS_EN
        ,
        .stat_branches(stat_branches),
        .stat_mispredicts(stat_mispredicts),
        .stat_squashed(stat_squashed)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc,
                         input logic [31:0] off, input logic p,
                         input logic pt);
        bus.in_valid      = v;
        bus.in_pc         = pc;
        bus.in_offset     = off;
        bus.in_predicate  = p;
        bus.in_pred_taken = pt;
    endtask

    task automatic test_reset();
        #2;
        tests++;
        if (bus.out_valid !== 1'b0 || bus.flush_req !== 1'b0
            || bus.in_ready !== 1'b0 || bus.out_target !== 32'h0
            || bus.out_taken !== 1'b0 || bus.out_mispredict !== 1'b0
            || bus.out_redirect_pc !== 32'h0) begin
            fails++;
            $display("FAIL reset_outputs: got v=%b f=%b r=%b t=%h want 0 0 0 0",
                     bus.out_valid, bus.flush_req, bus.in_ready, bus.out_target);
        end
        tick();
        rst = 1'b0;
        #1;
        tests++;
        if (bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_ready: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_basic();
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h1000, 32'h20, 1'b1, 1'b1);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_taken !== 1'b1
            || bus.out_target !== 32'h1020
            || bus.out_redirect_pc !== 32'h1020
            || bus.out_mispredict !== 1'b0 || bus.flush_req !== 1'b0) begin
            fails++;
            $display("FAIL basic_resolve: got v=%b t=%b tgt=%h rd=%h m=%b f=%b want 1 1 1020 1020 0 0",
                     bus.out_valid, bus.out_taken, bus.out_target,
                     bus.out_redirect_pc, bus.out_mispredict, bus.flush_req);
        end
        tick();
        tests++;
        if (bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL basic_pop: got out_valid=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_mispredict_squash();
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h2000, 32'hFFFF_FFF0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_taken !== 1'b0
            || bus.out_target !== 32'h1FF0
            || bus.out_redirect_pc !== 32'h2004
            || bus.out_mispredict !== 1'b1 || bus.flush_req !== 1'b1) begin
            fails++;
            $display("FAIL mispredict_resolve: got v=%b t=%b tgt=%h rd=%h m=%b f=%b want 1 0 1ff0 2004 1 1",
                     bus.out_valid, bus.out_taken, bus.out_target,
                     bus.out_redirect_pc, bus.out_mispredict, bus.flush_req);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h2100 + 32'(i * 4), 32'h40, 1'b1, 1'b0);
            #1;
            tests++;
            if (bus.in_ready !== 1'b1) begin
                fails++;
                $display("FAIL squash_ready_%0d: got %b want 1", i, bus.in_ready);
            end
            tick();
            tests++;
            if (bus.out_valid !== 1'b0 || bus.flush_req !== 1'b1) begin
                fails++;
                $display("FAIL squash_drop_%0d: got v=%b f=%b want 0 1",
                         i, bus.out_valid, bus.flush_req);
            end
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        bus.redirect_ack = 1'b1;
        tick();
        bus.redirect_ack = 1'b0;
        tests++;
        if (bus.flush_req !== 1'b0) begin
            fails++;
            $display("FAIL squash_ack: got flush_req=%b want 0", bus.flush_req);
        end
`ifdef BRANCH_RESOLVE_STATS_EN
        tests++;
        if (stat_branches !== 32'd2 || stat_mispredicts !== 32'd1
            || stat_squashed !== 32'd3) begin
            fails++;
            $display("FAIL stats: got b=%0d m=%0d s=%0d want 2 1 3",
                     stat_branches, stat_mispredicts, stat_squashed);
        end
`endif
        drive(1'b1, 32'h3000, 32'h10, 1'b1, 1'b1);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_target !== 32'h3010) begin
            fails++;
            $display("FAIL post_ack_enqueue: got v=%b tgt=%h want 1 3010",
                     bus.out_valid, bus.out_target);
        end
        tick();
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h100 + 32'(i * 4), 32'h10, 1'b1, 1'b1);
            #1;
            tests++;
            if (bus.in_ready !== (i < 2)) begin
                fails++;
                $display("FAIL full_ready_%0d: got %b want %b",
                         i, bus.in_ready, (i < 2));
            end
            if (i < 2) tick();
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        tests++;
        if (bus.in_ready !== 1'b1 || bus.out_target !== 32'h114) begin
            fails++;
            $display("FAIL pop_when_full: got r=%b tgt=%h want 1 114",
                     bus.in_ready, bus.out_target);
        end
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        #1;
        tests++;
        if (bus.out_target !== 32'h114 || bus.out_valid !== 1'b1) begin
            fails++;
            $display("FAIL order_second: got tgt=%h want 114", bus.out_target);
        end
        tick();
        tests++;
        if (bus.out_target !== 32'h118 || bus.out_valid !== 1'b1) begin
            fails++;
            $display("FAIL order_third: got tgt=%h want 118", bus.out_target);
        end
        tick();
        tests++;
        if (bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL drain_empty: got out_valid=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_wrap();
        bus.out_ready = 1'b1;
        drive(1'b1, 32'hFFFF_FFFC, 32'h8, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_target !== 32'h4
            || bus.out_redirect_pc !== 32'h0
            || bus.out_mispredict !== 1'b0 || bus.out_taken !== 1'b0) begin
            fails++;
            $display("FAIL wrap_arith: got v=%b tgt=%h rd=%h m=%b want 1 4 0 0",
                     bus.out_valid, bus.out_target, bus.out_redirect_pc,
                     bus.out_mispredict);
        end
        tick();
    endtask

    task automatic test_ack_discard();
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h700, 32'h10, 1'b1, 1'b0);
        tick();
        drive(1'b1, 32'h704, 32'h10, 1'b1, 1'b1);
        bus.redirect_ack = 1'b1;
        tick();
        bus.redirect_ack = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tests++;
        if (bus.out_valid !== 1'b0 || bus.flush_req !== 1'b0) begin
            fails++;
            $display("FAIL ack_same_cycle_discard: got v=%b f=%b want 0 0",
                     bus.out_valid, bus.flush_req);
        end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h400, 32'h10, 1'b1, 1'b1);
        tick();
        drive(1'b1, 32'h500, 32'h10, 1'b0, 1'b1);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tests++;
        if (bus.out_valid !== 1'b1 || bus.flush_req !== 1'b1
            || bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL pre_reset_state: got v=%b f=%b r=%b want 1 1 1",
                     bus.out_valid, bus.flush_req, bus.in_ready);
        end
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (bus.out_valid !== 1'b0 || bus.flush_req !== 1'b0
            || bus.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: got v=%b f=%b r=%b want 0 0 0",
                     bus.out_valid, bus.flush_req, bus.in_ready);
        end
        #2;
        rst = 1'b0;
        #1;
        tests++;
        if (bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL post_reset_ready: got %b want 1", bus.in_ready);
        end
        drive(1'b1, 32'h600, 32'h10, 1'b1, 1'b1);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_target !== 32'h610
            || bus.flush_req !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_enqueue: got v=%b tgt=%h f=%b want 1 610 0",
                     bus.out_valid, bus.out_target, bus.flush_req);
        end
`ifdef BRANCH_RESOLVE_STATS_EN
        tests++;
        if (stat_branches !== 32'd1 || stat_squashed !== 32'd0) begin
            fails++;
            $display("FAIL stats_reset: got b=%0d s=%0d want 1 0",
                     stat_branches, stat_squashed);
        end
`endif
    endtask

    initial begin
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        bus.out_ready    = 1'b0;
        bus.redirect_ack = 1'b0;
        test_reset();
        test_basic();
        test_mispredict_squash();
        test_backpressure();
        test_wrap();
        test_ack_discard();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/branch_resolve_stage.md
Name: branch_resolve_stage

Overview:
- Sits directly downstream of the comparison unit in the execute pipeline.
- Consumes its 1-bit predicate together with the branch PC, offset and predicted direction.
- Resolves the actual direction, target and redirect PC, and detects mispredictions.
- Buffers resolved results in a small output FIFO and runs a squash state machine that drops wrong-path branches until fetch acknowledges the redirect.

Parameters:
- WIDTH, 32, PC/offset width in bits.
- DEPTH, 2, output FIFO entries (power of two, >= 2).
- INSN_BYTES, 4, fall-through increment added to PC.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  branch present on input
- in_ready  output  1  stage can accept input this cycle
- in_predicate  input  1  predicate from comparison unit (1 = condition true = taken)
- in_pred_taken  input  1  direction predicted by fetch
- in_pc  input  WIDTH  branch PC
- in_offset  input  WIDTH  two's-complement branch offset
- out_valid  output  1  FIFO head valid
- out_ready  input  1  consumer pops head when out_valid & out_ready
- out_taken  output  1  resolved direction
- out_target  output  WIDTH  in_pc + in_offset
- out_redirect_pc  output  WIDTH  out_taken ? out_target : in_pc + INSN_BYTES
- out_mispredict  output  1  resolved direction != predicted direction
- flush_req  output  1  high while in SQUASH
- redirect_ack  input  1  fetch has taken the redirect

Behaviour:
- Reset (async, on rst high): FIFO empty, state RUN. Outputs: out_valid=0, out_taken=0, out_target=0, out_redirect_pc=0, out_mispredict=0, flush_req=0, in_ready=0 while rst high.
- Reset mid-operation discards all FIFO contents and any pending squash.
- Accept: a transfer occurs when in_valid & in_ready at a rising edge.
- Resolve: purely from the accepted inputs.
  - taken = in_predicate
  - target = in_pc + in_offset, modulo 2^WIDTH (wrap, no overflow flag)
  - fall-through = in_pc + INSN_BYTES, modulo 2^WIDTH
  - mispredict = taken ^ in_pred_taken
- Latency: accepted at edge N, visible at FIFO head after edge N if FIFO was empty (out_valid high in cycle N+1). No combinational input-to-output path.
- Output FIFO:
  - Registered, DEPTH entries, in-order.
  - out_* driven from head; head stable while out_valid & !out_ready.
  - Pop on out_valid & out_ready.
- State RUN:
  - in_ready = (count < DEPTH); no same-cycle pass-through when full.
  - Accepted branch is enqueued.
  - If the enqueued branch has mispredict=1, go to SQUASH at the same edge.
  - redirect_ack in RUN is ignored.
- State SQUASH:
  - flush_req=1, in_ready=1.
  - Accepted inputs are discarded (never enqueued).
  - FIFO continues to drain normally.
  - redirect_ack=1 -> RUN at next edge.
  - An input accepted in the same cycle as redirect_ack is still discarded.
- Simultaneous push and pop with FIFO full: push is blocked (in_ready=0). Pop proceeds; in_ready rises the following cycle.
- Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both operations occur.
- Pointers wrap modulo DEPTH; full/empty are derived from a count register of width clog2(DEPTH)+1.

Optional Feature:
- Macro: BRANCH_RESOLVE_STATS_EN.
- When defined, add outputs:
  - stat_branches (32 bits): increments on every enqueued branch.
  - stat_mispredicts (32 bits): increments on every enqueued mispredicted branch.
  - stat_squashed (32 bits): increments on every input discarded in SQUASH.
- All three counters reset to 0 on rst and wrap at 2^32.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Basic resolve:
  - Stimulus: WIDTH=32, in_pc=0x1000, in_offset=0x20, in_predicate=1, in_pred_taken=1, out_ready=1.
  - Response: next cycle out_valid=1, out_taken=1, out_target=0x1020, out_redirect_pc=0x1020, out_mispredict=0, flush_req=0.
- Not-taken mispredict and squash:
  - Stimulus: in_pc=0x2000, in_offset=0xFFFFFFF0, in_predicate=0, in_pred_taken=1.
  - Response: out_target=0x1FF0, out_redirect_pc=0x2004, out_mispredict=1, flush_req=1.
  - Then 3 more inputs are accepted and produce no output. redirect_ack pulse -> flush_req=0 next cycle, and the next input is enqueued.
- Backpressure/full:
  - Stimulus: out_ready=0, push 3 correctly predicted branches back-to-back.
  - Response: first two enqueued, in_ready=0 on the third. Raise out_ready for 1 cycle -> pop of first entry, in_ready=1 next cycle, order preserved (PCs 0x100, 0x104, 0x108).
- Wrap-around arithmetic:
  - Stimulus: in_pc=0xFFFFFFFC, in_offset=0x8, in_predicate=0, in_pred_taken=0.
  - Response: out_target=0x00000004, out_redirect_pc=0x00000000, out_mispredict=0.
- Reset mid-operation:
  - Stimulus: FIFO holds 2 entries and state is SQUASH; assert rst asynchronously between edges.
  - Response: out_valid=0 and flush_req=0 immediately; after rst release, in_ready=1 and the first input is enqueued in RUN.
- Stats (with BRANCH_RESOLVE_STATS_EN):
  - Stimulus: the mispredict/squash scenario above.
  - Response: stat_branches=1, stat_mispredicts=1, stat_squashed=3.
